// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if -- handshake and serial-line bundle for the configurable UART
// transmitter. The master side (system) drives tick, start, payload and parity
// mode; the slave side (transmitter) returns busy, done pulse and serial line.
interface uart_tx_cfg_if #(
   parameter int DBIT = 8
);
   logic            s_tick;
   logic            tx_start;
   logic [DBIT-1:0] tx_data_in;
   logic [1:0]      parity_mode;
   logic            tx_busy;
   logic            tx_done_tick;
   logic            tx;

   modport master (
      output s_tick, tx_start, tx_data_in, parity_mode,
      input  tx_busy, tx_done_tick, tx
   );

   modport slave (
      input  s_tick, tx_start, tx_data_in, parity_mode,
      output tx_busy, tx_done_tick, tx
   );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- oversampled UART transmitter with configurable data width,
// ticks per bit and stop length. Frame: start bit, DBIT data bits LSB first,
// optional parity bit, stop period.
// Optional feature macro: UART_TX_PARITY_EN. When defined, parity_mode 01/10
// inserts an even/odd parity bit; when undefined the PARITY state and parity
// logic are not built and parity_mode is ignored.
module uart_tx_cfg #(
   parameter int DBIT       = 8,
   parameter int OS_TICKS   = 16,
   parameter int STOP_TICKS = 16
) (
   input logic          clk,
   input logic          rst,
   uart_tx_cfg_if.slave bus
);

   // Tick counter must reach STOP_TICKS-1, which is the largest terminal count.
   localparam int TICK_W = $clog2(STOP_TICKS);
   localparam int BIT_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OS_TICKS - 1);
   localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Even parity of the payload; odd parity is its inverse.
   function automatic logic parity_even(input logic [DBIT-1:0] d);
      return ^d;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   state_t            state_q, state_d;
   logic [TICK_W-1:0] tick_q,  tick_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [DBIT-1:0]   shreg_q, shreg_d;
   logic              tx_q,    tx_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
`ifdef UART_TX_PARITY_EN
   logic              par_en_q,  par_en_d;
   logic              par_bit_q, par_bit_d;
`else
   // parity_mode stays on the port but has no effect in this build.
   logic              unused_parity_s;
   assign unused_parity_s = ^bus.parity_mode;
`endif

   // Next-state, next-output and datapath computation for the frame FSM.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // A tick in the acceptance cycle is deliberately not counted.
            if (bus.tx_start) begin
               shreg_d = bus.tx_data_in;
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
               par_en_d  = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
               par_bit_d = parity_even(bus.tx_data_in) ^ (bus.parity_mode == 2'b10);
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (bus.s_tick) begin
               if (tick_q == OS_LAST) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = ST_DATA;
                  tx_d    = shreg_q[0];
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
         ST_DATA: begin
            if (bus.s_tick) begin
               if (tick_q == OS_LAST) begin
                  tick_d  = '0;
                  shreg_d = shreg_q >> 1;
                  if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     if (par_en_q) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                     end else begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                     end
`else
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
`endif
                  end else begin
                     bit_d = bit_q + BIT_W'(1);
                     // Next bit is the LSB of the register after this shift.
                     tx_d  = shreg_q[1];
                  end
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bus.s_tick) begin
               if (tick_q == OS_LAST) begin
                  tick_d  = '0;
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
`endif
         ST_STOP: begin
            if (bus.s_tick) begin
               if (tick_q == STOP_LAST) begin
                  tick_d  = '0;
                  state_d = ST_IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end else begin
               tick_d = tick_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
`endif
      end
   end

   assign bus.tx           = tx_q;
   assign bus.tx_busy      = busy_q;
   assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg -- scoreboard bench for uart_tx_cfg. Stimulus pushes the
// expected frame (line levels per bit slot, stop length) into a queue; a
// monitor per instance detects each start bit, pops and checks every slot
// level, the tick count per slot, busy and the done pulse.
module tb_uart_tx_cfg;

   localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_ON = 1'b1;
`else
   localparam bit PAR_ON = 1'b0;
`endif

   typedef struct {
      logic [10:0] lv;
      int          nseg;
      int          stop;
   } frame_t;

   typedef struct {
      logic [7:0] d;
      logic [1:0] m;
      bit         pe;
      logic       pb;
      bit         al;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_cfg_if #(.DBIT(8)) b8();
   uart_tx_cfg_if #(.DBIT(7)) b7();

   uart_tx_cfg #(.DBIT(8), .OS_TICKS(16), .STOP_TICKS(16)) dut8 (
      .clk(clk), .rst(rst), .bus(b8.slave));
   uart_tx_cfg #(.DBIT(7), .OS_TICKS(16), .STOP_TICKS(32)) dut7 (
      .clk(clk), .rst(rst), .bus(b7.slave));

   frame_t exp_q0[$];
   frame_t exp_q1[$];
   int     vecs = 0;
   int     fails = 0;
   bit     abort_mode = 1'b0;
   bit     mon_busy[2];

   function automatic logic get_tx(input int inst);
      return (inst == 0) ? b8.tx : b7.tx;
   endfunction
   function automatic logic get_busy(input int inst);
      return (inst == 0) ? b8.tx_busy : b7.tx_busy;
   endfunction
   function automatic logic get_done(input int inst);
      return (inst == 0) ? b8.tx_done_tick : b7.tx_done_tick;
   endfunction
   function automatic int qsize(input int inst);
      return (inst == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic frame_t mk(input logic [8:0] data, input int dbit,
                                 input bit par_en, input logic par_bit, input int stop);
      frame_t f;
      f.lv    = '0;
      f.lv[0] = 1'b0;
      for (int i = 0; i < dbit; i++) f.lv[i+1] = data[i];
      f.nseg = dbit + 1;
      if (par_en) begin
         f.lv[dbit+1] = par_bit;
         f.nseg       = dbit + 2;
      end
      f.stop = stop;
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Oversampling tick: one-clk pulse every 4 clocks, shared by both DUTs.
   initial begin
      b8.s_tick = 1'b0;
      b7.s_tick = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 b8.s_tick = 1'b1; b7.s_tick = 1'b1;
         @(posedge clk);
         #1 b8.s_tick = 1'b0; b7.s_tick = 1'b0;
      end
   end

   task automatic check_frame(input int inst, input frame_t e);
      int   need, cnt, guard;
      logic lvl, seen;
      bit   busy_bad;
      busy_bad = 1'b0;
      for (int s = 0; s <= e.nseg; s++) begin
         lvl   = (s < e.nseg) ? e.lv[s] : 1'b1;
         need  = (s < e.nseg) ? OS : e.stop;
         seen  = lvl;
         cnt   = 0;
         guard = 0;
         if (s > 0) @(negedge clk);
         forever begin
            if (get_tx(inst) !== lvl && seen === lvl) seen = get_tx(inst);
            if (get_busy(inst) !== 1'b1) busy_bad = 1'b1;
            if (b8.s_tick === 1'b1) cnt++;
            if (cnt == need) break;
            guard++;
            if (guard > need * 8 + 16) break;
            @(negedge clk);
         end
         chk($sformatf("i%0d_slot%0d_level", inst, s), {31'd0, seen}, {31'd0, lvl});
         chk($sformatf("i%0d_slot%0d_ticks", inst, s), cnt, need);
      end
      @(negedge clk);
      chk($sformatf("i%0d_done_pulse", inst), {31'd0, get_done(inst)}, 32'd1);
      chk($sformatf("i%0d_busy_after", inst), {31'd0, get_busy(inst)}, 32'd0);
      chk($sformatf("i%0d_busy_in_frame_dropped", inst), {31'd0, busy_bad}, 32'd0);
   endtask

   task automatic monitor(input int inst);
      frame_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 || (inst == 0 && abort_mode) || get_tx(inst) !== 1'b0) continue;
         if (qsize(inst) == 0) begin
            chk($sformatf("i%0d_unexpected_frame", inst), 32'd1, 32'd0);
            for (int k = 0; k < 4000 && get_tx(inst) !== 1'b1; k++) @(negedge clk);
            continue;
         end
         e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         mon_busy[inst] = 1'b1;
         check_frame(inst, e);
         mon_busy[inst] = 1'b0;
      end
   endtask

   initial begin
      mon_busy[0] = 1'b0;
      mon_busy[1] = 1'b0;
      fork
         monitor(0);
         monitor(1);
      join_none
   end

   task automatic send(input int inst, input logic [8:0] data, input logic [1:0] mode, input bit align);
      int g;
      @(posedge clk); #2;
      if (align) begin
         g = 0;
         while (b8.s_tick !== 1'b1 && g < 16) begin
            @(posedge clk); #2;
            g++;
         end
      end
      if (inst == 0) begin
         b8.tx_data_in = data[7:0]; b8.parity_mode = mode; b8.tx_start = 1'b1;
      end else begin
         b7.tx_data_in = data[6:0]; b7.parity_mode = mode; b7.tx_start = 1'b1;
      end
      @(posedge clk); #2;
      b8.tx_start = 1'b0;
      b7.tx_start = 1'b0;
   endtask

   task automatic wait_idle(input int inst);
      int g;
      for (g = 0; g < 4000; g++) begin
         @(negedge clk);
         if (qsize(inst) == 0 && !mon_busy[inst]) break;
      end
      chk($sformatf("i%0d_frame_timeout", inst), {31'd0, (g >= 4000)}, 32'd0);
   endtask

   vec_t v8[7] = '{
      '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0},
      '{8'hA3, 2'b11, 1'b0, 1'b0, 1'b1},
      '{8'h07, 2'b01, 1'b1, 1'b1, 1'b0},
      '{8'h07, 2'b10, 1'b1, 1'b0, 1'b1},
      '{8'h00, 2'b01, 1'b1, 1'b0, 1'b0},
      '{8'hFF, 2'b10, 1'b1, 1'b1, 1'b1},
      '{8'h96, 2'b01, 1'b1, 1'b0, 1'b0}
   };

   initial begin
      int  g, cnt;
      bit  bad;
      rst = 1'b1;
      b8.tx_start = 1'b0; b8.tx_data_in = '0; b8.parity_mode = 2'b00;
      b7.tx_start = 1'b0; b7.tx_data_in = '0; b7.parity_mode = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_tx8",   {31'd0, b8.tx},           32'd1);
      chk("rst_busy8", {31'd0, b8.tx_busy},      32'd0);
      chk("rst_done8", {31'd0, b8.tx_done_tick}, 32'd0);
      chk("rst_tx7",   {31'd0, b7.tx},           32'd1);
      chk("rst_busy7", {31'd0, b7.tx_busy},      32'd0);
      chk("rst_done7", {31'd0, b7.tx_done_tick}, 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      repeat (4) @(posedge clk);

      // Directed frames on the 8-bit, 1-stop instance.
      foreach (v8[i]) begin
         exp_q0.push_back(mk({1'b0, v8[i].d}, 8, PAR_ON & v8[i].pe, v8[i].pb, 16));
         send(0, {1'b0, v8[i].d}, v8[i].m, v8[i].al);
         wait_idle(0);
      end

      // 7-bit, 2-stop instance: all ones, then 0010101 with even parity 1.
      exp_q1.push_back(mk(9'h07F, 7, 1'b0, 1'b0, 32));
      send(1, 9'h07F, 2'b00, 1'b0);
      wait_idle(1);
      exp_q1.push_back(mk(9'h015, 7, PAR_ON, 1'b1, 32));
      send(1, 9'h015, 2'b01, 1'b1);
      wait_idle(1);

      // tx_start held through a frame while the payload changes; second
      // frame must start in the done cycle with the value present then.
      exp_q0.push_back(mk(9'h0A5, 8, 1'b0, 1'b0, 16));
      exp_q0.push_back(mk(9'h03C, 8, 1'b0, 1'b0, 16));
      @(posedge clk); #2;
      b8.parity_mode = 2'b00; b8.tx_data_in = 8'hA5; b8.tx_start = 1'b1;
      for (int k = 0; k < 10; k++) begin
         repeat (20) @(posedge clk);
         #2 b8.tx_data_in = 8'(k * 37 + 1);
      end
      b8.tx_data_in = 8'h3C;
      for (g = 0; g < 2000; g++) begin
         @(negedge clk);
         if (b8.tx_done_tick === 1'b1) break;
      end
      chk("b2b_done_seen", {31'd0, (g < 2000)}, 32'd1);
      @(negedge clk);
      chk("b2b_done_one_clk", {31'd0, b8.tx_done_tick}, 32'd0);
      chk("b2b_tx_start",     {31'd0, b8.tx},           32'd0);
      chk("b2b_busy",         {31'd0, b8.tx_busy},      32'd1);
      b8.tx_start = 1'b0;
      wait_idle(0);

      // Reset during data bit 3 of 0xA5 (bit 3 is 0).
      abort_mode = 1'b1;
      send(0, 9'h0A5, 2'b00, 1'b0);
      cnt = 0;
      for (g = 0; g < 1000 && cnt < 70; g++) begin
         @(negedge clk);
         if (b8.s_tick === 1'b1) cnt++;
      end
      chk("abort_pre_tx",   {31'd0, b8.tx},      32'd0);
      chk("abort_pre_busy", {31'd0, b8.tx_busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_tx",   {31'd0, b8.tx},           32'd1);
      chk("abort_busy", {31'd0, b8.tx_busy},      32'd0);
      chk("abort_done", {31'd0, b8.tx_done_tick}, 32'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (b8.tx_done_tick !== 1'b0 || b8.tx !== 1'b1 || b8.tx_busy !== 1'b0) bad = 1'b1;
      end
      chk("abort_stays_idle", {31'd0, bad}, 32'd0);
      abort_mode = 1'b0;
      exp_q0.push_back(mk(9'h03A, 8, PAR_ON, 1'b0, 16));
      send(0, 9'h03A, 2'b01, 1'b0);
      wait_idle(0);

      repeat (20) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame; legal range 5..9.
REQ-002 Parameter OS_TICKS, default 16: s_tick pulses per bit period; legal range 8..32.
REQ-003 Parameter STOP_TICKS, default 16: s_tick pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2 at OS_TICKS=16); legal range OS_TICKS..2*OS_TICKS.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 s_tick  input  1  oversampling tick; one-clk pulse.
REQ-007 tx_start  input  1  request to send one frame.
REQ-008 tx_data_in  input  DBIT  frame payload; LSB transmitted first.
REQ-009 parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-010 tx_busy  output  1  high while a frame is in progress.
REQ-011 tx_done_tick  output  1  one-clk pulse at frame completion.
REQ-012 tx  output  1  serial line; registered, idle high.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-014 IDLE SHALL drive tx=1; on tx_start=1 it SHALL latch tx_data_in and parity_mode, clear the tick and bit counters, and enter START.
REQ-015 tx SHALL be registered: tx falls to 0 exactly one clk after the cycle in which tx_start is accepted.
REQ-016 tx_start SHALL be ignored in every state other than IDLE; the latched payload SHALL be immune to later input changes.
REQ-017 An s_tick in the acceptance cycle SHALL NOT be counted; counting begins in the first START cycle.
REQ-018 START, DATA and PARITY SHALL each last exactly OS_TICKS s_tick pulses per bit; STOP SHALL last exactly STOP_TICKS pulses.
REQ-019 In START, tx SHALL be 0; on the final tick the FSM SHALL go to DATA with the bit index set to 0.
REQ-020 In DATA, tx SHALL be the current LSB of the shift register; after each bit the register SHALL shift right; after bit DBIT-1 the FSM SHALL go to PARITY if the latched mode is 01/10, else to STOP.
REQ-021 The even parity bit SHALL be the XOR of the DBIT latched bits; the odd parity bit SHALL be its inverse.
REQ-022 In STOP, tx SHALL be 1; on the final tick the FSM SHALL return to IDLE.
REQ-023 tx_done_tick SHALL be registered and high for exactly one clk: the first IDLE cycle after STOP.
REQ-024 tx_start=1 in the cycle tx_done_tick=1 SHALL be accepted, giving back-to-back frames with no idle bit-time.
REQ-025 tx_busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-026 Counter widths SHALL be sized from the parameters with no wrap-around before the terminal count.

Reset
REQ-027 While rst=1: state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, and all counters and the shift register=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with no tx_done_tick issued.
REQ-029 After release, the first frame SHALL require a fresh tx_start.

Configuration
REQ-030 Macro UART_TX_PARITY_EN defined: parity behaviour per REQ-020/021 is compiled in.
REQ-031 Macro undefined: the PARITY state and parity logic SHALL be absent; the parity_mode port SHALL remain present and be ignored; every frame is start+DATA+stop.

Verification
REQ-032 DBIT=8, OS_TICKS=16, mode 00, send 0x55 -> tx = 0,1,0,1,0,1,0,1,0,1 with each level held for 16 ticks; tx_done_tick after 160 ticks; tx_busy high throughout.
REQ-033 Macro on, mode 01, send 0x07 -> parity bit 1; mode 10, send 0x07 -> parity bit 0; frame length 176 ticks.
REQ-034 DBIT=7, STOP_TICKS=32, send 0x7F -> 7 data bits of 1, then stop held for 32 ticks, then done.
REQ-035 tx_start held high through a frame with changing tx_data_in -> exactly one frame carrying the first value; a second frame starts in the done cycle (back-to-back, no gap).
REQ-036 rst pulsed during DATA bit 3 -> tx=1 and tx_busy=0 immediately; no tx_done_tick; the next tx_start produces a correct full frame.
